// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array result collector.
// Holds the sample width, the number of results per convolution map,
// the collector FSM state encoding and the value used to seed the
// running max-pool register.
package sa_pkg;

    localparam int DATA_W  = 8;
    localparam int NUM_RES = 4;

    // idx runs 0..NUM_RES inclusive, so it needs one bit more than a slot index
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] NUM_RES_IDX = IDX_W'(NUM_RES);

    // Most negative two's complement value, so the first sample always wins the max
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VALID   = 2'd2
    } state_t;

endpackage

// File: rtl/sa_relu_max.sv
// Combinational ReLU followed by a signed two-input maximum.
// Ports:
//   sample  : raw result sample from the array (two's complement)
//   run_max : current running maximum of the map
//   relu_q  : ReLU enable latched at start
//   v       : sample after optional ReLU (negative values forced to 0)
//   new_max : signed max(run_max, v)
module sa_relu_max
    import sa_pkg::*;
(
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] run_max,
    input  logic              relu_q,
    output logic [DATA_W-1:0] v,
    output logic [DATA_W-1:0] new_max
);

    // ReLU only needs the sign bit; then a plain signed compare picks the max
    always_comb begin
        v       = (relu_q && sample[DATA_W-1]) ? '0 : sample;
        new_max = ($signed(v) > $signed(run_max)) ? v : run_max;
    end

endmodule

// File: rtl/sa_result_collector.sv
// Downstream collector for the systolic-array convolution engine.
// Gathers four serial results into a 2x2 map (row-major), applies an
// optional ReLU, tracks a 2x2 max-pool value and hands the finished map
// to the next stage with a valid/ready handshake. Protocol violations
// from the array raise a sticky error flag.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   start, relu_en        : arm a new collection, ReLU select sampled on start
//   sa_en_result, sa_result, sa_done : result stream from the array
//   out_ready             : downstream accepts the map
//   c_1_1..c_2_2          : captured map
//   pool_max              : signed maximum of the map
//   out_valid, busy       : handshake valid, collection in progress
//   proto_err             : sticky protocol error
module sa_result_collector
    import sa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              relu_en,
    input  logic              sa_en_result,
    input  logic [DATA_W-1:0] sa_result,
    input  logic              sa_done,
    input  logic              out_ready,
    output logic [DATA_W-1:0] c_1_1,
    output logic [DATA_W-1:0] c_1_2,
    output logic [DATA_W-1:0] c_2_1,
    output logic [DATA_W-1:0] c_2_2,
    output logic [DATA_W-1:0] pool_max,
    output logic              out_valid,
    output logic              busy,
    output logic              proto_err
);

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  idx;
    logic              relu_q;
    logic              accept;
    logic              overflow;
    logic [IDX_W-1:0]  count_now;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] new_max;

    sa_relu_max u_relu_max (
        .sample  (sa_result),
        .run_max (pool_max),
        .relu_q  (relu_q),
        .v       (v),
        .new_max (new_max)
    );

    // A strobe is taken only while slots remain; a strobe past the last slot is an overflow.
    // count_now includes the current strobe so done may arrive together with the last result.
    always_comb begin
        accept    = (state == COLLECT) && sa_en_result && (idx < NUM_RES_IDX);
        overflow  = (state == COLLECT) && sa_en_result && (idx == NUM_RES_IDX);
        count_now = idx + {{(IDX_W-1){1'b0}}, accept};
    end

    assign out_valid = (state == VALID);
    assign busy      = (state == COLLECT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // start overrides everything else, including a pending handshake
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = COLLECT;
        end else begin
            unique case (state)
                IDLE:    next_state = IDLE;
                COLLECT: if (sa_done) next_state = (count_now == NUM_RES_IDX) ? VALID : IDLE;
                VALID:   if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Map, pool and error registers; the map holds in IDLE and VALID until the next start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            c_1_1     <= '0;
            c_1_2     <= '0;
            c_2_1     <= '0;
            c_2_2     <= '0;
            pool_max  <= '0;
            relu_q    <= 1'b0;
            proto_err <= 1'b0;
        end else if (start) begin
            idx       <= '0;
            c_1_1     <= '0;
            c_1_2     <= '0;
            c_2_1     <= '0;
            c_2_2     <= '0;
            pool_max  <= MOST_NEG;
            relu_q    <= relu_en;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                unique case (idx[1:0])
                    2'd0: c_1_1 <= v;
                    2'd1: c_1_2 <= v;
                    2'd2: c_2_1 <= v;
                    default: c_2_2 <= v;
                endcase
                idx      <= idx + 1'b1;
                pool_max <= new_max;
            end
            if (overflow || ((state == COLLECT) && sa_done && (count_now != NUM_RES_IDX))) begin
                proto_err <= 1'b1;
            end
            if ((state == VALID) && (sa_en_result || sa_done)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sa_result_collector.sv
// Directed self-checking bench for sa_result_collector.
module tb_sa_result_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       relu_en;
    logic       sa_en_result;
    logic [7:0] sa_result;
    logic       sa_done;
    logic       out_ready;
    logic [7:0] c_1_1, c_1_2, c_2_1, c_2_2, pool_max;
    logic       out_valid, busy, proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    sa_result_collector dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .relu_en      (relu_en),
        .sa_en_result (sa_en_result),
        .sa_result    (sa_result),
        .sa_done      (sa_done),
        .out_ready    (out_ready),
        .c_1_1        (c_1_1),
        .c_1_2        (c_1_2),
        .c_2_1        (c_2_1),
        .c_2_2        (c_2_2),
        .pool_max     (pool_max),
        .out_valid    (out_valid),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] val, input logic done);
        sa_en_result = 1'b1;
        sa_result    = val;
        sa_done      = done;
        tick();
        sa_en_result = 1'b0;
        sa_done      = 1'b0;
    endtask

    task automatic pulse_start(input logic relu);
        start   = 1'b1;
        relu_en = relu;
        tick();
        start   = 1'b0;
        relu_en = 1'b0;
    endtask

    task automatic send_map(input logic relu, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] a3);
        pulse_start(relu);
        strobe(a0, 1'b0);
        strobe(a1, 1'b0);
        strobe(a2, 1'b0);
        strobe(a3, 1'b1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2, pool_max} !== 40'h0 ||
            {out_valid, busy, proto_err} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_state got map=%h pool=%h flags=%b want all 0",
                     {c_1_1, c_1_2, c_2_1, c_2_2}, pool_max, {out_valid, busy, proto_err});
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        send_map(1'b0, 8'd5, 8'd12, 8'd3, 8'd7);
        n_checks++;
        if ({out_valid, busy} !== 2'b10) begin
            n_fail++; $display("[TB] FAIL basic_valid got %b want 10", {out_valid, busy});
        end
        n_checks++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2} !== 32'h050C0307) begin
            n_fail++; $display("[TB] FAIL basic_map got %h want 050c0307", {c_1_1, c_1_2, c_2_1, c_2_2});
        end
        n_checks++;
        if (pool_max !== 8'd12) begin
            n_fail++; $display("[TB] FAIL basic_pool got %h want 0c", pool_max);
        end
        handshake();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL basic_handshake out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2, pool_max} !== 40'h050C03070C) begin
            n_fail++; $display("[TB] FAIL basic_retain got %h want 050c03070c",
                               {c_1_1, c_1_2, c_2_1, c_2_2, pool_max});
        end
    endtask

    task automatic test_relu_signed();
        send_map(1'b1, 8'hF0, 8'h02, 8'h81, 8'h00);
        n_checks++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2, pool_max} !== 40'h0002000002) begin
            n_fail++; $display("[TB] FAIL relu_on got %h want 0002000002",
                               {c_1_1, c_1_2, c_2_1, c_2_2, pool_max});
        end
        handshake();
        send_map(1'b0, 8'hF0, 8'h02, 8'h81, 8'h00);
        n_checks++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2, pool_max} !== 40'hF002810002) begin
            n_fail++; $display("[TB] FAIL relu_off got %h want f002810002",
                               {c_1_1, c_1_2, c_2_1, c_2_2, pool_max});
        end
        handshake();
        send_map(1'b0, 8'hF0, 8'hF1, 8'h81, 8'hFF);
        n_checks++;
        if (pool_max !== 8'hFF || out_valid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL all_negative pool got %h valid %b want ff 1", pool_max, out_valid);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        send_map(1'b0, 8'd21, 8'd22, 8'd23, 8'd24);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 ||
                {c_1_1, c_1_2, c_2_1, c_2_2, pool_max} !== 40'h1516171818) unstable++;
        end
        n_checks++;
        if (unstable != 0) begin
            n_fail++; $display("[TB] FAIL backpressure_hold got %0d unstable cycles want 0", unstable);
        end
        strobe(8'd9, 1'b0);
        n_checks++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2, pool_max} !== 40'h1516171818 || out_valid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL stray_strobe_map got %h valid %b want 1516171818 1",
                               {c_1_1, c_1_2, c_2_1, c_2_2, pool_max}, out_valid);
        end
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL stray_strobe_err got %b want 1", proto_err);
        end
        handshake();
    endtask

    task automatic test_protocol_errors();
        int seen_valid = 0;
        pulse_start(1'b0);
        strobe(8'd1, 1'b0);
        strobe(8'd2, 1'b0);
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) seen_valid++;
            tick();
        end
        n_checks++;
        if (seen_valid != 0 || busy !== 1'b0 || proto_err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL early_done got valid_cycles=%0d busy=%b err=%b want 0 0 1",
                               seen_valid, busy, proto_err);
        end
        pulse_start(1'b0);
        strobe(8'd10, 1'b0);
        strobe(8'd20, 1'b0);
        strobe(8'd30, 1'b0);
        strobe(8'd40, 1'b0);
        strobe(8'd50, 1'b0);
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
        n_checks++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2, pool_max} !== 40'h0A141E2828 ||
            {out_valid, proto_err} !== 2'b11) begin
            n_fail++; $display("[TB] FAIL overflow got %h valid/err %b want 0a141e2828 11",
                               {c_1_1, c_1_2, c_2_1, c_2_2, pool_max}, {out_valid, proto_err});
        end
        handshake();
    endtask

    task automatic test_abort_restart();
        pulse_start(1'b0);
        strobe(8'd99, 1'b0);
        strobe(8'd98, 1'b0);
        start        = 1'b1;
        sa_en_result = 1'b1;
        sa_result    = 8'd77;
        tick();
        start        = 1'b0;
        sa_en_result = 1'b0;
        strobe(8'd1, 1'b0);
        strobe(8'd2, 1'b0);
        strobe(8'd3, 1'b0);
        strobe(8'd4, 1'b1);
        n_checks++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2, pool_max} !== 40'h0102030404 ||
            {out_valid, proto_err} !== 2'b10) begin
            n_fail++; $display("[TB] FAIL abort_restart got %h valid/err %b want 0102030404 10",
                               {c_1_1, c_1_2, c_2_1, c_2_2, pool_max}, {out_valid, proto_err});
        end
        handshake();
    endtask

    task automatic test_async_reset();
        int wrong = 0;
        pulse_start(1'b0);
        strobe(8'd33, 1'b0);
        strobe(8'd44, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({c_1_1, c_1_2, c_2_1, c_2_2, pool_max} !== 40'h0 ||
            {out_valid, busy, proto_err} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL async_reset got %h flags %b want 0 000",
                               {c_1_1, c_1_2, c_2_1, c_2_2, pool_max}, {out_valid, busy, proto_err});
        end
        #3;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sa_en_result = 1'b1;
            sa_result    = 8'd55;
            sa_done      = (i == 4);
            tick();
            if ({out_valid, busy, proto_err} !== 3'b000 || c_1_1 !== 8'h00) wrong++;
        end
        sa_en_result = 1'b0;
        sa_done      = 1'b0;
        n_checks++;
        if (wrong != 0) begin
            n_fail++; $display("[TB] FAIL idle_after_reset got %0d bad cycles want 0", wrong);
        end
    endtask

    initial begin
        start        = 1'b0;
        relu_en      = 1'b0;
        sa_en_result = 1'b0;
        sa_result    = 8'h00;
        sa_done      = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_basic();
        test_relu_signed();
        test_backpressure();
        test_protocol_errors();
        test_abort_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_result_collector.md
Name: sa_result_collector

Overview:
Downstream stage of the systolic-array convolution module.
- Captures the serial stream of four 8-bit results (sa_result strobed by sa_en_result, terminated by sa_done) into a 2x2 output map c_1_1..c_2_2.
- Optionally applies ReLU and computes a 2x2 max-pool value.
- Presents the completed map to the next stage through a valid/ready handshake.
- Flags protocol violations from the array.

Parameters:
DATA_W, 8, width of one result sample (two's complement)
NUM_RES, 4, results per convolution (2x2 output map, row-major)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse issued together with en_sa to the array; arms collection
relu_en  input  1  ReLU select, sampled on start
sa_en_result  input  1  result strobe from array
sa_result  input  DATA_W  result sample, valid when sa_en_result=1
sa_done  input  1  end-of-convolution pulse from array
out_ready  input  1  downstream accepts the map
c_1_1, c_1_2, c_2_1, c_2_2  output  DATA_W  captured (post-ReLU) map, row-major
pool_max  output  DATA_W  signed maximum of the four map entries
out_valid  output  1  map and pool_max are valid and stable
busy  output  1  high in COLLECT
proto_err  output  1  sticky protocol-error flag, cleared by start or reset

Behaviour:
- Reset (reset=0, async): state=IDLE, idx=0, all c_* = 0, pool_max = 0, out_valid=0, busy=0, proto_err=0, relu_q=0.
- States: IDLE, COLLECT, VALID.
- IDLE: strobes and done are ignored. On start: clear c_* to 0, idx=0, pool_max=8'h80 (most negative), relu_q<=relu_en, proto_err=0, then go to COLLECT.
- COLLECT (busy=1): on each sa_en_result with idx<NUM_RES:
  - v = (relu_q && sa_result[DATA_W-1]) ? 0 : sa_result.
  - Write v to slot idx (0=c_1_1, 1=c_1_2, 2=c_2_1, 3=c_2_2); idx++.
  - pool_max <= signed max(pool_max, v).
  - Capture-to-register latency is 1 cycle.
- Strobe with idx==NUM_RES: data discarded, proto_err<=1.
- sa_done in COLLECT:
  - If idx==NUM_RES, or the same cycle carries the 4th strobe (count including current strobe ==4): go to VALID next cycle.
  - If fewer than 4 results: proto_err<=1, go to IDLE, out_valid stays 0.
- VALID: out_valid=1; c_* and pool_max held constant. When out_valid && out_ready: go to IDLE, out_valid drops the next cycle. Strobes or done in VALID: ignored, proto_err<=1.
- start in COLLECT or VALID: abort the current map (no handshake), perform the IDLE start actions, go to COLLECT. start has priority over a simultaneous strobe, done, or out_ready; a strobe in the start cycle is dropped.
- Compares are signed; no arithmetic widening, so the output width equals DATA_W.
- After a handshake, c_* and pool_max retain their values in IDLE until the next start.
- Minimum strobe spacing: back-to-back strobes (every cycle) must be accepted.

Decomposition:
- Shared package sa_pkg holds:
  - DATA_W and NUM_RES
  - state encoding constants (IDLE=2'd0, COLLECT=2'd1, VALID=2'd2)
  - the most-negative constant used to seed pool_max
- One sub-module, sa_relu_max: combinational ReLU plus signed 2-input max (inputs: sample, running max, relu_q; outputs: v, new max). All other logic stays in the top.

Test Plan:
1. Basic map: start (relu_en=0), strobes 8'd5, 8'd12, 8'd3, 8'd7 back-to-back, sa_done with the 4th strobe -> next cycle out_valid=1, c=(5,12,3,7), pool_max=12; out_ready=1 -> out_valid=0 next cycle.
2. ReLU and signed max: relu_en=1, strobes 8'hF0, 8'h02, 8'h81, 8'h00 -> c=(0,2,0,0), pool_max=2. Same stream with relu_en=0 -> c=(F0,02,81,00), pool_max=8'h02. All-negative stream F0, F1, 81, FF with relu_en=0 -> pool_max=8'hFF.
3. Backpressure: out_ready=0 for 10 cycles after VALID -> out_valid and outputs stable; stray strobe 8'd9 during VALID -> outputs unchanged, proto_err=1.
4. Protocol errors: sa_done after 2 strobes -> IDLE, out_valid never asserts, proto_err=1. 5 strobes before done -> 5th discarded, proto_err=1, map equals the first 4.
5. Abort/restart: start mid-COLLECT after 2 strobes, then 4 new strobes 1, 2, 3, 4 -> c=(1,2,3,4), proto_err=0.
6. Async reset: assert reset=0 mid-COLLECT between clock edges -> all outputs 0 immediately. After release, the FSM stays IDLE until start.
